// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mult_share_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first requester with
// req set, searching upward from the one after last_grant (wrapping).
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDW = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id
);

  logic [IDW-1:0] idx;
  logic           found;

  // Rotating priority search; the first hit after last_grant wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_id   = idx;
        grant[idx] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential multiplier between N_REQ requesters: round-robin
// accept, start/done sequencing with a watchdog, and a single tagged
// response channel.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 64,
  localparam int IDW    = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [2*WIDTH-1:0]     resp_product,
  output logic                   resp_error,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_multiplicand,
  output logic [WIDTH-1:0]       mul_multiplier,
  input  logic [2*WIDTH-1:0]     mul_product,
  input  logic                   mul_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [IDW-1:0]     last_grant_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               mul_start_q;
  logic               resp_valid_q;
  logic [2*WIDTH-1:0] resp_product_q;
  logic               resp_error_q;

  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     grant_id;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Operand mux for the currently winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end else begin
        sel_a = sel_a;
        sel_b = sel_b;
      end
    end
  end

  // Accept strobe is combinational so the grant lands in the IDLE cycle itself;
  // it is forced low while reset is held.
  always_comb begin
    if (state_q == ST_IDLE && !rst) begin
      req_ready = grant;
    end else begin
      req_ready = '0;
    end
  end

  // Saturating watchdog increment.
  always_comb begin
    if (cnt_q == CW'(TIMEOUT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Controller FSM with operand latches, watchdog and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= IDW'(N_REQ - 1);
      id_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      cnt_q          <= '0;
      mul_start_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_product_q <= '0;
      resp_error_q   <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            id_q        <= grant_id;
            a_q         <= sel_a;
            b_q         <= sel_b;
            mul_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          cnt_q <= cnt_d;
          // cnt_q == 0 marks the blanking cycle where a stale done is ignored.
          if ((cnt_q != '0) && mul_done) begin
            resp_product_q <= mul_product;
            resp_error_q   <= 1'b0;
            resp_valid_q   <= 1'b1;
            state_q        <= ST_RESP;
          end else if (cnt_d == CW'(TIMEOUT)) begin
            resp_product_q <= '0;
            resp_error_q   <= 1'b1;
            resp_valid_q   <= 1'b1;
            state_q        <= ST_RESP;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            last_grant_q <= id_q;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_start        = mul_start_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign resp_valid       = resp_valid_q;
  assign resp_id          = id_q;
  assign resp_product     = resp_product_q;
  assign resp_error       = resp_error_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: a stub multiplier with programmable latency,
// a transaction-level model checked every cycle, and directed plus random tests.
module tb_mult_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [1:0]     resp_id;
  logic [2*W-1:0] resp_product;
  logic           resp_error;
  logic           mul_start;
  logic [W-1:0]   mul_multiplicand;
  logic [W-1:0]   mul_multiplier;
  logic [2*W-1:0] m_prod = '0;
  logic           m_done = 1'b0;

  mult_share_ctrl #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .resp_error(resp_error),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_product(m_prod), .mul_done(m_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Stub multiplier: done is a level that stays high until the next start and
  // is still stale in the first cycle after start; product is junk while busy.
  int     lat_sel = 3;
  bit     hang = 1'b0;
  int     m_lat = 2;
  bit     m_hang = 1'b0;
  bit     m_run = 1'b0;
  int     m_cnt = 0;
  longint m_res = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0; m_prod <= '0; m_run <= 1'b0; m_cnt <= 0;
    end else if (mul_start) begin
      m_run  <= 1'b1;
      m_cnt  <= 1;
      m_lat  <= lat_sel;
      m_hang <= hang;
      m_res  <= longint'($signed(mul_multiplicand)) * longint'($signed(mul_multiplier));
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if ((m_cnt + 1 >= m_lat) && !m_hang) begin
        m_done <= 1'b1; m_prod <= m_res; m_run <= 1'b0;
      end else begin
        m_done <= 1'b0; m_prod <= {$urandom, $urandom};
      end
    end
  end

  // Transaction model state.
  bit         outst = 1'b0;
  int         acc = 0;
  int         cur_id = 0;
  logic [W-1:0] cur_a, cur_b;
  longint     cur_exp = 0;
  int         model_last = N - 1;
  bit         rv_seen = 1'b0;
  int         first_rv = 0;
  logic [N-1:0] xfer_seen = '0;
  int         starts_seen = 0;
  int         readies_seen = 0;
  int         q_grants[$];
  int         r_id[$];
  longint     r_prod[$];
  bit         r_err[$];
  int         r_lat[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  // Per-cycle comparison of every DUT output against the transaction model.
  always @(negedge clk) begin
    int  g;
    int  elat;
    bit  exp_rv;
    bit  werr;
    if (rst) begin
      outst = 1'b0; model_last = N - 1; rv_seen = 1'b0; xfer_seen = '0;
    end else begin
      xfer_seen = req_valid & req_ready;
      if (req_ready != '0) readies_seen++;
      if (mul_start) starts_seen++;
      if (outst) begin
        chk(req_ready == '0, "ready_while_busy", longint'(req_ready), 0);
      end else if (req_valid != '0) begin
        g = rr_pick(req_valid, model_last);
        chk(req_ready == N'(1 << g), "grant", longint'(req_ready), longint'(1 << g));
        outst = 1'b1; acc = cyc; cur_id = g;
        cur_a = req_a[g*W +: W]; cur_b = req_b[g*W +: W];
        cur_exp = longint'($signed(cur_a)) * longint'($signed(cur_b));
        q_grants.push_back(g);
      end else begin
        chk(req_ready == '0, "ready_idle", longint'(req_ready), 0);
      end
      chk(mul_start == (outst && cyc == acc + 1), "mul_start", longint'(mul_start),
          longint'(outst && cyc == acc + 1));
      if (outst && cyc > acc) begin
        chk(mul_multiplicand == cur_a, "mul_multiplicand", longint'(mul_multiplicand), longint'(cur_a));
        chk(mul_multiplier == cur_b, "mul_multiplier", longint'(mul_multiplier), longint'(cur_b));
      end
      werr = m_hang || (m_lat > TO);
      exp_rv = 1'b0;
      if (outst && cyc > acc + 1) begin
        elat = werr ? 2 + TO : 2 + m_lat;
        exp_rv = (cyc >= acc + elat);
      end
      chk(resp_valid == exp_rv, "resp_valid", longint'(resp_valid), longint'(exp_rv));
      if (resp_valid && exp_rv) begin
        if (!rv_seen) begin rv_seen = 1'b1; first_rv = cyc; end
        chk(int'(resp_id) == cur_id, "resp_id", longint'(resp_id), cur_id);
        chk(resp_error == werr, "resp_error", longint'(resp_error), longint'(werr));
        chk($signed(resp_product) == (werr ? 64'sd0 : cur_exp), "resp_product",
            $signed(resp_product), werr ? 0 : cur_exp);
        if (resp_ready) begin
          r_id.push_back(cur_id); r_prod.push_back($signed(resp_product));
          r_err.push_back(resp_error); r_lat.push_back(first_rv - acc);
          model_last = cur_id; outst = 1'b0; rv_seen = 1'b0;
        end
      end
    end
  end

  // Stimulus helpers.
  int reload[N] = '{default: 0};
  bit rand_mode = 1'b0;

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  task automatic put(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer_seen[i]) begin
        if (reload[i] > 0) begin
          reload[i]--; put(i, rnd_op(), rnd_op());
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) put(i, rnd_op(), rnd_op());
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      resp_ready = 1'($urandom_range(0, 1));
      lat_sel = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(2, 8);
    end
  endtask

  task automatic wait_resps(input int n, input int budget, input string nm);
    int k = 0;
    while (r_id.size() < n && k < budget) begin step(); k++; end
    chk(r_id.size() >= n, nm, r_id.size(), n);
  endtask

  task automatic clear_logs();
    q_grants.delete(); r_id.delete(); r_prod.delete(); r_err.delete(); r_lat.delete();
  endtask

  task automatic check_outputs_zero(input string nm);
    chk(req_ready == '0, {nm, "_req_ready"}, longint'(req_ready), 0);
    chk(resp_valid == 1'b0 && resp_error == 1'b0 && mul_start == 1'b0,
        {nm, "_flags"}, longint'({resp_valid, resp_error, mul_start}), 0);
    chk(resp_id == '0 && resp_product == '0, {nm, "_resp"}, $signed(resp_product), 0);
    chk(mul_multiplicand == '0 && mul_multiplier == '0, {nm, "_operands"},
        longint'(mul_multiplicand), 0);
  endtask

  initial begin
    int     k;
    int     s0, rd0, n0;
    bit     stable;
    logic [1:0]     snap_id;
    logic [2*W-1:0] snap_p;
    logic           snap_e;

    // Reset state, with requests pending to prove req_ready is held low.
    req_valid = 4'hF;
    #3;
    check_outputs_zero("reset");
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention: all four valid, first grant goes to requester 0.
    clear_logs(); lat_sel = 3;
    put(0, 32'd23, 32'd3);
    put(1, 32'd2323, 32'd45);
    put(2, -32'sd5678, 32'd1234);
    put(3, 32'h8000_0000, 32'h8000_0000);
    wait_resps(4, 200, "contention_wait");
    if (r_id.size() >= 4) begin
      chk(q_grants[0] == 0 && q_grants[1] == 1 && q_grants[2] == 2 && q_grants[3] == 3,
          "contention_order", q_grants[0]*1000 + q_grants[1]*100 + q_grants[2]*10 + q_grants[3], 123);
      chk(r_prod[0] == 64'sd69, "prod_23x3", r_prod[0], 69);
      chk(r_prod[1] == 64'sd104535, "prod_2323x45", r_prod[1], 104535);
      chk(r_prod[2] == -64'sd7006652, "prod_m5678x1234", r_prod[2], -7006652);
      chk(r_prod[3] == 64'sd4611686018427387904, "prod_minxmin", r_prod[3], 64'sd4611686018427387904);
    end

    // Single requester: latency must be 2 + L.
    clear_logs(); lat_sel = 5; s0 = starts_seen;
    put(0, 32'd10, -32'sd5);
    wait_resps(1, 100, "single_wait");
    repeat (3) step();
    chk(starts_seen - s0 == 1, "single_start_pulses", starts_seen - s0, 1);
    if (r_id.size() >= 1) begin
      chk(r_id[0] == 0 && r_err[0] == 1'b0, "single_id_err", r_id[0], 0);
      chk(r_prod[0] == -64'sd50, "single_product", r_prod[0], -50);
      chk(r_lat[0] == 7, "single_latency", r_lat[0], 7);
    end

    // Fairness: requesters 1 and 3 held valid for six operations.
    clear_logs(); lat_sel = 2;
    reload[1] = 2; reload[3] = 2;
    put(1, rnd_op(), rnd_op());
    put(3, rnd_op(), rnd_op());
    wait_resps(6, 300, "fair_wait");
    if (q_grants.size() >= 6) begin
      k = 0;
      for (int i = 0; i < 6; i++) k = k * 10 + q_grants[i];
      chk(k == 131313, "fair_order", k, 131313);
    end

    // Response backpressure held for five cycles.
    clear_logs(); lat_sel = 3; resp_ready = 1'b0;
    put(0, 32'd7, 32'd9);
    put(2, -32'sd3, 32'd11);
    k = 0;
    while (!resp_valid && k < 60) begin step(); k++; end
    chk(resp_valid == 1'b1, "bp_wait", longint'(resp_valid), 1);
    snap_id = resp_id; snap_p = resp_product; snap_e = resp_error;
    s0 = starts_seen; rd0 = readies_seen; stable = 1'b1;
    repeat (5) begin
      step();
      if (resp_valid !== 1'b1 || resp_id !== snap_id || resp_product !== snap_p || resp_error !== snap_e)
        stable = 1'b0;
    end
    chk(stable, "bp_stable", longint'(stable), 1);
    chk(starts_seen == s0, "bp_no_start", starts_seen - s0, 0);
    chk(readies_seen == rd0, "bp_no_ready", readies_seen - rd0, 0);
    chk(snap_p == 64'd63, "bp_product", $signed(snap_p), 63);
    resp_ready = 1'b1;
    wait_resps(2, 100, "bp_drain");
    if (r_id.size() >= 2) chk(r_id[1] == 2, "bp_second_id", r_id[1], 2);

    // Watchdog: hung multiplier, then normal op, then done-latency boundaries.
    clear_logs(); hang = 1'b1;
    put(0, 32'd123, 32'd456);
    wait_resps(1, 100, "wd_wait");
    hang = 1'b0; lat_sel = 4;
    if (r_id.size() >= 1) begin
      chk(r_err[0] == 1'b1 && r_prod[0] == 0, "wd_error", r_prod[0], 0);
      chk(r_lat[0] == 2 + TO, "wd_latency", r_lat[0], 2 + TO);
    end
    put(1, 32'd100, -32'sd100);
    wait_resps(2, 100, "wd_next_wait");
    if (r_id.size() >= 2) chk(r_prod[1] == -64'sd10000 && r_err[1] == 1'b0, "wd_next_product", r_prod[1], -10000);
    lat_sel = TO;
    put(2, 32'd3, 32'd4);
    wait_resps(3, 100, "wd_edge_ok_wait");
    if (r_id.size() >= 3) chk(r_err[2] == 1'b0 && r_lat[2] == 2 + TO, "wd_edge_ok", r_lat[2], 2 + TO);
    lat_sel = TO + 1;
    put(3, 32'd5, 32'd6);
    wait_resps(4, 100, "wd_edge_err_wait");
    if (r_id.size() >= 4) chk(r_err[3] == 1'b1 && r_prod[3] == 0, "wd_edge_err", longint'(r_err[3]), 1);
    // Stale done from the late multiplier must be blanked on the next op.
    lat_sel = 2;
    put(0, -32'sd7, 32'd8);
    wait_resps(5, 100, "blank_wait");
    if (r_id.size() >= 5) chk(r_prod[4] == -64'sd56, "blank_product", r_prod[4], -56);

    // Reset in the middle of BUSY: immediate zero outputs, no response.
    clear_logs(); lat_sel = 20;
    put(3, 32'd1, 32'd2);
    k = 0;
    while (!(outst && cyc >= acc + 5) && k < 40) begin step(); k++; end
    chk(outst, "midrst_wait", longint'(outst), 1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) step();
    n0 = r_id.size();
    chk(n0 == 0, "midrst_no_resp", n0, 0);
    lat_sel = 3;
    put(2, 32'd50000, 32'd50000);
    wait_resps(1, 100, "midrst_next_wait");
    if (r_id.size() >= 1)
      chk(r_id[0] == 2 && r_prod[0] == 64'sd2500000000, "midrst_next", r_prod[0], 64'sd2500000000);

    // Random traffic with random backpressure and latency.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0; req_valid = '0; resp_ready = 1'b1; lat_sel = 2;
    k = 0;
    while (outst && k < 200) begin step(); k++; end
    chk(!outst, "drain", longint'(outst), 0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "bench timeout");
  end

endmodule
